// File: rtl/audio_pkg.sv
// Shared definitions for the serial audio transmit and receive paths.
package audio_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned FRAME_BITS     = 2 * DEFAULT_DATA_W;

  // Frame ordering shared with the transmit serializer: left word first, each word MSB first.
  localparam bit LEFT_FIRST = 1'b1;
  localparam bit MSB_FIRST  = 1'b1;

  typedef enum logic [0:0] {
    HUNT,
    RECV
  } rx_state_e;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out shift register; restart drops old contents and loads din as bit 0.
module sipo_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= restart ? {{(WIDTH - 1){1'b0}}, din} : {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/audio_serial_rx.sv
// Deserializes a framed stereo serial stream into parallel left/right words.
module audio_serial_rx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              s_clk,
  input  logic              rst_n,
  input  logic              sdin,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] audio_left,
  output logic [DATA_W-1:0] audio_right,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              locked
);

  localparam int unsigned FrameBits = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(FrameBits - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 shift_en;
  logic                 shift_restart;
  logic                 frame_done;
  logic                 sync_err;
  logic [FrameBits-2:0] shift_q;
  logic [FrameBits-1:0] frame_word;

  sipo_shift #(
    .WIDTH(FrameBits - 1)
  ) u_shift (
    .clk    (s_clk),
    .rst_n  (rst_n),
    .en     (shift_en),
    .restart(shift_restart),
    .din    (sdin),
    .q      (shift_q)
  );

  // The last bit bypasses the shifter so the words can be latched on the same edge.
  assign frame_word = {shift_q, sdin};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_en      = 1'b0;
    shift_restart = 1'b0;
    frame_done    = 1'b0;
    sync_err      = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (frame_sync) begin
          shift_en      = 1'b1;
          shift_restart = 1'b1;
          cnt_d         = CNT_W'(1);
          state_d       = RECV;
        end
      end
      RECV: begin
        if (cnt_q == '0 && !frame_sync) begin
          sync_err = 1'b1;
          cnt_d    = '0;
          state_d  = HUNT;
        end else if (cnt_q != '0 && frame_sync) begin
          // Early sync: treat this bit as the start of a fresh frame.
          sync_err      = 1'b1;
          shift_en      = 1'b1;
          shift_restart = 1'b1;
          cnt_d         = CNT_W'(1);
        end else if (cnt_q == LastBit) begin
          frame_done = 1'b1;
          cnt_d      = '0;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      audio_left   <= '0;
      audio_right  <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_valid <= frame_done;
      frame_err    <= sync_err;
      if (sync_err) begin
        locked <= 1'b0;
      end else if (frame_done) begin
        locked <= 1'b1;
      end
      if (frame_done) begin
        audio_left  <= LEFT_FIRST ? frame_word[FrameBits-1 -: DATA_W] : frame_word[DATA_W-1:0];
        audio_right <= LEFT_FIRST ? frame_word[DATA_W-1:0] : frame_word[FrameBits-1 -: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_audio_serial_rx.sv
// Directed self-checking bench for audio_serial_rx.
module tb_audio_serial_rx;

  logic        s_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdin = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        sample_valid;
  logic        frame_err;
  logic        locked;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int          cyc;
    logic [15:0] l;
    logic [15:0] r;
  } vrec_t;

  vrec_t vq[$];
  int    err_cnt = 0;
  int    cyc = 0;

  always #5 s_clk = ~s_clk;

  audio_serial_rx u_dut (
    .s_clk       (s_clk),
    .rst_n       (rst_n),
    .sdin        (sdin),
    .frame_sync  (frame_sync),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .sample_valid(sample_valid),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  // Record every valid pulse and error pulse just after the edge that produces it.
  always @(posedge s_clk) begin
    #1;
    cyc++;
    if (sample_valid === 1'b1) vq.push_back('{cyc, audio_left, audio_right});
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic drive(input logic d, input logic s);
    @(negedge s_clk);
    sdin = d;
    frame_sync = s;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    logic [31:0] w;
    w = {l, r};
    for (int i = 0; i < 32; i++) drive(w[31-i], i == 0);
  endtask

  task automatic do_reset;
    @(negedge s_clk);
    rst_n = 1'b0;
    sdin = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(negedge s_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge s_clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({audio_left, audio_right} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_words: got %h want 00000000", {audio_left, audio_right});
    end
    tests_run++;
    if ({sample_valid, frame_err, locked} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000", {sample_valid, frame_err, locked});
    end
    repeat (2) @(negedge s_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    send_frame(16'h1234, 16'hABCD);
    drive(1'b0, 1'b0);
    tests_run++;
    if (sample_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_valid: got %b want 1", sample_valid);
    end
    tests_run++;
    if ({audio_left, audio_right} !== 32'h1234ABCD) begin
      tests_failed++;
      $display("FAIL single_words: got %h want 1234abcd", {audio_left, audio_right});
    end
    tests_run++;
    if ({locked, frame_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_lock: got locked,err=%b want 10", {locked, frame_err});
    end
    drive(1'b0, 1'b0);
    tests_run++;
    if (sample_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse_width: got %b want 0", sample_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [3];
    int n0, e0;
    exp_w[0] = 32'h0001_8000;
    exp_w[1] = 32'hFFFF_0000;
    exp_w[2] = 32'h5A5A_A5A5;
    do_reset();
    n0 = vq.size();
    e0 = err_cnt;
    for (int f = 0; f < 3; f++) send_frame(exp_w[f][31:16], exp_w[f][15:0]);
    drive(1'b0, 1'b0);
    tests_run++;
    if (vq.size() - n0 !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want 3", vq.size() - n0);
    end else begin
      for (int f = 0; f < 3; f++) begin
        tests_run++;
        if ({vq[n0+f].l, vq[n0+f].r} !== exp_w[f]) begin
          tests_failed++;
          $display("FAIL b2b_words%0d: got %h want %h", f, {vq[n0+f].l, vq[n0+f].r}, exp_w[f]);
        end
      end
      for (int f = 1; f < 3; f++) begin
        tests_run++;
        if (vq[n0+f].cyc - vq[n0+f-1].cyc !== 32) begin
          tests_failed++;
          $display("FAIL b2b_spacing%0d: got %0d want 32", f, vq[n0+f].cyc - vq[n0+f-1].cyc);
        end
      end
    end
    tests_run++;
    if (err_cnt - e0 !== 0 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_lock: got errs=%0d locked=%b want 0 1", err_cnt - e0, locked);
    end
  endtask

  task automatic test_early_sync;
    logic [31:0] w;
    int n0, e0;
    do_reset();
    n0 = vq.size();
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) drive(i[0], i == 0);
    w = 32'h0F0F_F0F0;
    for (int i = 0; i < 32; i++) begin
      drive(w[31-i], i == 0);
      if (i == 1) begin
        tests_run++;
        if ({frame_err, locked} !== 2'b10) begin
          tests_failed++;
          $display("FAIL early_err_pulse: got err,locked=%b want 10", {frame_err, locked});
        end
      end
    end
    drive(1'b0, 1'b0);
    tests_run++;
    if (sample_valid !== 1'b1 || {audio_left, audio_right} !== 32'h0F0FF0F0) begin
      tests_failed++;
      $display("FAIL early_words: got v=%b %h want 1 0f0ff0f0", sample_valid,
               {audio_left, audio_right});
    end
    tests_run++;
    if (vq.size() - n0 !== 1 || err_cnt - e0 !== 1) begin
      tests_failed++;
      $display("FAIL early_counts: got valids=%0d errs=%0d want 1 1", vq.size() - n0,
               err_cnt - e0);
    end
  endtask

  task automatic test_missing_sync;
    int e0;
    do_reset();
    send_frame(16'hC3C3, 16'h3C3C);
    drive(1'b1, 1'b0);
    tests_run++;
    if (sample_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL miss_first_valid: got %b want 1", sample_valid);
    end
    drive(1'b1, 1'b0);
    tests_run++;
    if ({frame_err, locked} !== 2'b10) begin
      tests_failed++;
      $display("FAIL miss_err: got err,locked=%b want 10", {frame_err, locked});
    end
    tests_run++;
    if ({audio_left, audio_right} !== 32'hC3C33C3C) begin
      tests_failed++;
      $display("FAIL miss_hold: got %h want c3c33c3c", {audio_left, audio_right});
    end
    e0 = err_cnt;
    repeat (5) drive(1'b1, 1'b0);
    tests_run++;
    if (err_cnt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL miss_hunt_quiet: got %0d errs want 0", err_cnt - e0);
    end
    send_frame(16'h2468, 16'h1357);
    drive(1'b0, 1'b0);
    tests_run++;
    if (sample_valid !== 1'b1 || {audio_left, audio_right} !== 32'h24681357 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL miss_recover: got v=%b %h locked=%b want 1 24681357 1", sample_valid,
               {audio_left, audio_right}, locked);
    end
  endtask

  task automatic test_idle_noise;
    int n0, e0;
    do_reset();
    n0 = vq.size();
    e0 = err_cnt;
    repeat (100) drive(1'($urandom_range(1, 0)), 1'b0);
    tests_run++;
    if (vq.size() - n0 !== 0 || err_cnt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL idle_pulses: got valids=%0d errs=%0d want 0 0", vq.size() - n0,
               err_cnt - e0);
    end
    tests_run++;
    if ({audio_left, audio_right, locked} !== 33'h0) begin
      tests_failed++;
      $display("FAIL idle_outputs: got %h locked=%b want 0 0", {audio_left, audio_right}, locked);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] w;
    int n0;
    do_reset();
    send_frame(16'hA1A1, 16'hB2B2);
    w = 32'h7777_1111;
    for (int i = 0; i < 20; i++) drive(w[31-i], i == 0);
    @(negedge s_clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({audio_left, audio_right} !== 32'h0 || {sample_valid, frame_err, locked} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got %h flags=%b want 0 000", {audio_left, audio_right},
               {sample_valid, frame_err, locked});
    end
    @(negedge s_clk);
    rst_n = 1'b1;
    n0 = vq.size();
    send_frame(16'h7777, 16'h1111);
    drive(1'b0, 1'b0);
    tests_run++;
    if (vq.size() - n0 !== 1 || {audio_left, audio_right} !== 32'h77771111) begin
      tests_failed++;
      $display("FAIL midrst_frame: got valids=%0d %h want 1 77771111", vq.size() - n0,
               {audio_left, audio_right});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_idle_noise();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_serial_rx.md
Name: audio_serial_rx

Overview:
- Receive-side counterpart of the speaker-path serializer: deserializes a 32-bit stereo serial audio frame back into two parallel 16-bit words.
- Frames are marked by a one-cycle frame-sync pulse.
- Used for mic/ADC capture and for loopback checks of the DAC transmit chain.
- Sits between the external serial pins (s_clk domain) and the parallel audio datapath.

Parameters:
- DATA_W, 16, bits per channel word; frame length is 2*DATA_W, left channel first, MSB first.
- CNT_W, 5, bit-counter width; must equal clog2(2*DATA_W).

Ports:
- s_clk  input  1  serial bit clock; all logic on posedge. The transmitter changes data on negedge.
- rst_n  input  1  asynchronous, active-low reset.
- sdin  input  1  serial data bit.
- frame_sync  input  1  high for exactly one s_clk cycle, coincident with the left-channel MSB.
- audio_left  output  DATA_W  last complete left word.
- audio_right  output  DATA_W  last complete right word.
- sample_valid  output  1  one-cycle pulse when audio_left/audio_right update.
- frame_err  output  1  one-cycle pulse on a sync-position violation.
- locked  output  1  high once a good frame has been received; low after any error.

Behaviour:
- Reset (async, rst_n=0): state=HUNT, bit counter cnt=0, shift register=0. All outputs 0: audio_left, audio_right, sample_valid, frame_err, locked.
- cnt is the index (0..2*DATA_W-1) of the bit sampled at the next posedge. Bits 0..DATA_W-1 are left (MSB first); the remaining bits are right (MSB first).
- sample_valid and frame_err default to 0 every cycle, so each is a single-cycle pulse.
- HUNT state:
  - sdin is ignored while frame_sync=0.
  - On frame_sync=1: shift in sdin as bit 0, cnt<=1, go to RECV. frame_err is not asserted.
- RECV state, evaluated in priority order each posedge:
  1. cnt==0 and frame_sync=0 (missing sync): frame_err<=1, locked<=0, go to HUNT, cnt<=0. The sdin bit is discarded.
  2. cnt!=0 and frame_sync=1 (early sync): frame_err<=1, locked<=0. Discard the partial frame, shift sdin in as the new bit 0, cnt<=1, stay in RECV.
  3. cnt==2*DATA_W-1 (last right LSB): latch audio_left and audio_right from {shift[2*DATA_W-2:0], sdin}, sample_valid<=1, locked<=1, cnt<=0.
  4. Otherwise: shift sdin in, cnt<=cnt+1.
- Latency: outputs and sample_valid are visible one s_clk cycle after the posedge that samples the right-channel LSB.
- audio_left/audio_right hold their values between valid pulses, including across errors.
- Back-to-back frames: the sync for frame N+1 arrives at the posedge right after frame N's last bit (cnt==0). No gap is required or allowed.
- Boundary cases:
  - Sync on the same edge as the final bit (cnt==31) is rule 2. Frame is discarded, no sample_valid.
  - Reset mid-frame discards the partial frame immediately. Output words return to 0.
- Shift register is 2*DATA_W-1 bits; the final bit bypasses it directly into the output latch.

Decomposition:
- Shared package audio_pkg holds:
  - DATA_W default (16) and FRAME_BITS = 2*DATA_W;
  - the rx state enum {HUNT, RECV};
  - the MSB-first/left-first ordering constant, shared with the transmit serializer.
- One natural sub-module: sipo_shift, a parameterized serial-in/parallel-out register with clear. The FSM, counter and output latches stay in the top.

Test Plan:
1. Reset, then one frame with left=16'h1234, right=16'hABCD and sync on bit 0 -> sample_valid high 1 cycle after bit 31; outputs 1234/ABCD; locked=1; frame_err=0.
2. Three back-to-back frames (0001/8000, FFFF/0000, 5A5A/A5A5) -> exactly 3 valid pulses, 32 cycles apart, words correct, locked stays 1.
3. Sync asserted at cnt=10 mid-frame, then a full frame 0F0F/F0F0 -> frame_err pulse at that edge, no valid for the broken frame, then valid with 0F0F/F0F0.
4. After a good frame, omit the next sync -> frame_err at the expected cnt=0 edge; locked=0; HUNT; outputs hold previous words; recovery on the next sync.
5. Random sdin with frame_sync held 0 for 100 cycles after reset -> no sample_valid, no frame_err, outputs 0.
6. Assert rst_n=0 at cnt=20, release, then send frame 7777/1111 -> outputs 0 during reset, then exactly one valid with 7777/1111.
